mem_stage: RTL and testbench

- Memory stage of the 5-stage RV64 pipeline. Sits between execute and writeback.
- Consumes an execute_data_t from the EX/MEM boundary plus access size and signedness. Drives the data bus with a valid/data_ok handshake.
- Aligns and extends load data. Produces a registered memory_data_t for writeback.
- Raises a stall for the whole pipeline while a bus access is outstanding.

---
 rtl/mem_stage.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg / mem_stage
//
// Memory stage of the 5-stage RV64 pipeline, between execute and writeback.
// It accepts one instruction at a time from execute. A load or store that is
// aligned becomes a bus request, and the request is held until the bus
// returns data_ok. Load data is aligned and extended. The stage registers a
// memory_data_t for writeback. While a bus access is outstanding it stalls
// the whole pipeline.
//
// Ports:
//   i_clk, i_resetn           clock, asynchronous active-low reset
//   i_dataE                   instruction from execute (execute_data_t)
//   i_msize, i_munsigned      access size (0..3 = B/H/W/D), zero-extend loads
//   o_dreq_valid/addr/size/   bus request, stable from the holding register
//   o_dreq_strobe/data          until data_ok
//   i_dresp_data_ok/data      bus response (read data is 8-byte lane aligned)
//   o_dataM                   registered result to writeback (memory_data_t)
//   o_stallM                  hold all upstream stages this cycle
//   o_misalign                one-cycle pulse when a misaligned op is dropped
//
// state | meaning
// IDLE  | accepting from execute; ALU ops and misaligned ops retire directly
// REQ   | bus request outstanding, dreq_* driven from the holding register
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic [63:0] aluout;
        logic [63:0] writedata;
        logic [4:0]  dst;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic        skip;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic [63:0] aluout;
        logic [63:0] readdata;
        logic [4:0]  dst;
    } memory_data_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [63:0] MMIO_BOUND = 64'h8000_0000
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  execute_data_t i_dataE,
    input  logic [1:0]    i_msize,
    input  logic          i_munsigned,
    output logic          o_dreq_valid,
    output logic [63:0]   o_dreq_addr,
    output logic [2:0]    o_dreq_size,
    output logic [7:0]    o_dreq_strobe,
    output logic [63:0]   o_dreq_data,
    input  logic          i_dresp_data_ok,
    input  logic [63:0]   i_dresp_data,
    output memory_data_t  o_dataM,
    output logic          o_stallM,
    output logic          o_misalign
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    // Holding register for the outstanding bus access.
    logic         r_regwrite;
    logic         r_memtoreg;
    logic         r_is_load;
    logic [31:0]  r_raw_instr;
    logic [63:0]  r_pc;
    logic [63:0]  r_addr;
    logic [4:0]   r_dst;
    logic [1:0]   r_size;
    logic         r_unsigned;
    logic [7:0]   r_strobe;
    logic [63:0]  r_wdata;
    logic         r_skip;

    memory_data_t r_dataM;
    logic         r_misalign;

    logic [2:0]   w_off;
    logic         w_is_mem;
    logic         w_is_store;
    logic         w_misaligned;
    logic         w_below_bound;
    logic [7:0]   w_mask_base;
    logic [7:0]   w_strobe;
    logic [63:0]  w_wdata;
    logic [63:0]  w_rd_shift;
    logic [63:0]  w_load_fmt;
    logic         w_capture;
    logic         w_stall;
    logic         w_misalign_next;
    memory_data_t w_dataM_next;

    // Decode of the incoming instruction (only acted on in IDLE).
    always_comb begin
        w_off         = i_dataE.aluout[2:0];
        w_is_mem      = i_dataE.memread | i_dataE.memwrite;
        // A load takes priority if both flags are ever set together.
        w_is_store    = i_dataE.memwrite & ~i_dataE.memread;
        w_below_bound = (i_dataE.aluout < MMIO_BOUND);
        w_misaligned  = 1'b0;
        w_mask_base   = 8'h01;
        case (i_msize)
            2'd0: begin
                w_misaligned = 1'b0;
                w_mask_base  = 8'h01;
            end
            2'd1: begin
                w_misaligned = i_dataE.aluout[0];
                w_mask_base  = 8'h03;
            end
            2'd2: begin
                w_misaligned = |i_dataE.aluout[1:0];
                w_mask_base  = 8'h0F;
            end
            default: begin
                w_misaligned = |i_dataE.aluout[2:0];
                w_mask_base  = 8'hFF;
            end
        endcase
        w_strobe = w_is_store ? (w_mask_base << w_off) : 8'h00;
        w_wdata  = i_dataE.writedata << {w_off, 3'b000};
    end

    // Load formatting from the held request; response lanes are 8-byte aligned.
    always_comb begin
        w_rd_shift = i_dresp_data >> {r_addr[2:0], 3'b000};
        w_load_fmt = '0;
        case (r_size)
            2'd0: w_load_fmt = r_unsigned ? {56'b0, w_rd_shift[7:0]}
                                          : {{56{w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'd1: w_load_fmt = r_unsigned ? {48'b0, w_rd_shift[15:0]}
                                          : {{48{w_rd_shift[15]}}, w_rd_shift[15:0]};
            2'd2: w_load_fmt = r_unsigned ? {32'b0, w_rd_shift[31:0]}
                                          : {{32{w_rd_shift[31]}}, w_rd_shift[31:0]};
            default: w_load_fmt = w_rd_shift;
        endcase
    end

    // Next-state, stall and writeback result.
    always_comb begin
        w_next_state    = r_state;
        w_stall         = 1'b0;
        w_capture       = 1'b0;
        w_misalign_next = 1'b0;
        w_dataM_next    = '0;
        case (r_state)
            IDLE: begin
                if (i_dataE.valid) begin
                    if (!w_is_mem) begin
                        w_dataM_next.valid     = 1'b1;
                        w_dataM_next.regwrite  = i_dataE.regwrite;
                        w_dataM_next.memtoreg  = i_dataE.memtoreg;
                        w_dataM_next.raw_instr = i_dataE.raw_instr;
                        w_dataM_next.pc        = i_dataE.pc;
                        w_dataM_next.aluout    = i_dataE.aluout;
                        w_dataM_next.dst       = i_dataE.dst;
                    end else if (w_misaligned) begin
                        // Dropped op still retires so writeback sees the pc,
                        // but it must not write a register.
                        w_dataM_next.valid     = 1'b1;
                        w_dataM_next.skip      = w_below_bound;
                        w_dataM_next.memtoreg  = i_dataE.memtoreg;
                        w_dataM_next.raw_instr = i_dataE.raw_instr;
                        w_dataM_next.pc        = i_dataE.pc;
                        w_dataM_next.aluout    = i_dataE.aluout;
                        w_dataM_next.dst       = i_dataE.dst;
                        w_misalign_next        = 1'b1;
                    end else begin
                        w_capture    = 1'b1;
                        w_stall      = 1'b1;
                        w_next_state = REQ;
                    end
                end
            end
            REQ: begin
                w_stall = ~i_dresp_data_ok;
                if (i_dresp_data_ok) begin
                    w_next_state           = IDLE;
                    w_dataM_next.valid     = 1'b1;
                    w_dataM_next.skip      = r_skip;
                    w_dataM_next.regwrite  = r_regwrite;
                    w_dataM_next.memtoreg  = r_memtoreg;
                    w_dataM_next.raw_instr = r_raw_instr;
                    w_dataM_next.pc        = r_pc;
                    w_dataM_next.aluout    = r_addr;
                    w_dataM_next.readdata  = r_is_load ? w_load_fmt : 64'h0;
                    w_dataM_next.dst       = r_dst;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= IDLE;
            r_dataM    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_dataM    <= w_dataM_next;
            r_misalign <= w_misalign_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_is_load   <= 1'b0;
            r_raw_instr <= '0;
            r_pc        <= '0;
            r_addr      <= '0;
            r_dst       <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_strobe    <= '0;
            r_wdata     <= '0;
            r_skip      <= 1'b0;
        end else if (w_capture) begin
            r_regwrite  <= i_dataE.regwrite;
            r_memtoreg  <= i_dataE.memtoreg;
            r_is_load   <= i_dataE.memread;
            r_raw_instr <= i_dataE.raw_instr;
            r_pc        <= i_dataE.pc;
            r_addr      <= i_dataE.aluout;
            r_dst       <= i_dataE.dst;
            r_size      <= i_msize;
            r_unsigned  <= i_munsigned;
            r_strobe    <= w_strobe;
            r_wdata     <= w_wdata;
            r_skip      <= w_below_bound;
        end
    end

    // Bus outputs are forced to zero outside REQ so a stale holding register
    // never leaks onto the bus.
    always_comb begin
        o_dreq_valid  = (r_state == REQ);
        o_dreq_addr   = o_dreq_valid ? r_addr : 64'h0;
        o_dreq_size   = o_dreq_valid ? {1'b0, r_size} : 3'b000;
        o_dreq_strobe = o_dreq_valid ? r_strobe : 8'h00;
        o_dreq_data   = o_dreq_valid ? r_wdata : 64'h0;
        o_stallM      = w_stall;
        o_dataM       = r_dataM;
        o_misalign    = r_misalign;
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic          clk;
    logic          resetn;
    execute_data_t dataE;
    logic [1:0]    msize;
    logic          munsigned;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    memory_data_t  dataM;
    logic          stallM;
    logic          misalign;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .i_clk           (clk),
        .i_resetn        (resetn),
        .i_dataE         (dataE),
        .i_msize         (msize),
        .i_munsigned     (munsigned),
        .o_dreq_valid    (dreq_valid),
        .o_dreq_addr     (dreq_addr),
        .o_dreq_size     (dreq_size),
        .o_dreq_strobe   (dreq_strobe),
        .o_dreq_data     (dreq_data),
        .i_dresp_data_ok (dresp_data_ok),
        .i_dresp_data    (dresp_data),
        .o_dataM         (dataM),
        .o_stallM        (stallM),
        .o_misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load (rd=1) or store (rd=0) that is aligned; nwait REQ cycles before data_ok.
    task automatic do_mem(input string tag, input logic [63:0] addr, input logic [1:0] size,
                          input logic uns, input logic rd, input logic [63:0] wdata,
                          input logic [63:0] rdata, input int nwait,
                          input logic [7:0] exp_strb, input logic [63:0] exp_wd,
                          input logic [63:0] exp_rd, input logic exp_skip);
        dataE           = '0;
        dataE.valid     = 1'b1;
        dataE.regwrite  = rd;
        dataE.memtoreg  = rd;
        dataE.memread   = rd;
        dataE.memwrite  = ~rd;
        dataE.raw_instr = 32'h0000_2003;
        dataE.pc        = 64'h8000_0100;
        dataE.aluout    = addr;
        dataE.writedata = wdata;
        dataE.dst       = 5'd7;
        msize           = size;
        munsigned       = uns;
        dresp_data_ok   = 1'b0;
        #1;
        chk({tag, ".accept_stall"}, 64'(stallM), 64'd1);
        chk({tag, ".accept_noreq"}, 64'(dreq_valid), 64'd0);
        tick();
        chk({tag, ".req_dataM_valid"}, 64'(dataM.valid), 64'd0);
        for (int i = 0; i < nwait; i++) begin
            chk({tag, ".wait_valid"}, 64'(dreq_valid), 64'd1);
            chk({tag, ".wait_addr"}, dreq_addr, addr);
            chk({tag, ".wait_stall"}, 64'(stallM), 64'd1);
            tick();
        end
        dresp_data_ok = 1'b1;
        dresp_data    = rdata;
        #1;
        chk({tag, ".ok_valid"}, 64'(dreq_valid), 64'd1);
        chk({tag, ".ok_addr"}, dreq_addr, addr);
        chk({tag, ".ok_size"}, 64'(dreq_size), 64'({1'b0, size}));
        chk({tag, ".ok_strobe"}, 64'(dreq_strobe), 64'(exp_strb));
        chk({tag, ".ok_wdata"}, dreq_data, exp_wd);
        chk({tag, ".ok_stall"}, 64'(stallM), 64'd0);
        tick();
        dresp_data_ok = 1'b0;
        dataE.valid   = 1'b0;
        #1;
        chk({tag, ".wb_valid"}, 64'(dataM.valid), 64'd1);
        chk({tag, ".wb_readdata"}, dataM.readdata, exp_rd);
        chk({tag, ".wb_skip"}, 64'(dataM.skip), 64'(exp_skip));
        chk({tag, ".wb_regwrite"}, 64'(dataM.regwrite), 64'(rd));
        chk({tag, ".wb_dst"}, 64'(dataM.dst), 64'd7);
        chk({tag, ".wb_aluout"}, dataM.aluout, addr);
        chk({tag, ".wb_noreq"}, 64'(dreq_valid), 64'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        dataE         = '0;
        msize         = 2'd0;
        munsigned     = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;

        // Reset state
        tick();
        tick();
        chk("rst.dataM", 64'(dataM == '0), 64'd1);
        chk("rst.dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst.dreq_addr", dreq_addr, 64'd0);
        chk("rst.stallM", 64'(stallM), 64'd0);
        chk("rst.misalign", 64'(misalign), 64'd0);
        resetn = 1'b1;
        tick();

        // ALU op passes through in one cycle without stalling
        dataE           = '0;
        dataE.valid     = 1'b1;
        dataE.regwrite  = 1'b1;
        dataE.raw_instr = 32'h0000_0013;
        dataE.pc        = 64'h8000_0000;
        dataE.aluout    = 64'h1234;
        dataE.dst       = 5'd5;
        #1;
        chk("alu.stall", 64'(stallM), 64'd0);
        chk("alu.noreq", 64'(dreq_valid), 64'd0);
        tick();
        dataE.valid = 1'b0;
        #1;
        chk("alu.valid", 64'(dataM.valid), 64'd1);
        chk("alu.aluout", dataM.aluout, 64'h1234);
        chk("alu.dst", 64'(dataM.dst), 64'd5);
        chk("alu.skip", 64'(dataM.skip), 64'd0);
        chk("alu.regwrite", 64'(dataM.regwrite), 64'd1);
        chk("alu.pc", dataM.pc, 64'h8000_0000);
        chk("alu.readdata", dataM.readdata, 64'd0);
        chk("alu.stall_after", 64'(stallM), 64'd0);
        tick();
        chk("idle.valid0", 64'(dataM.valid), 64'd0);

        // Loads and stores
        do_mem("lb_s", 64'h8000_0003, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0000_0000_8000_0000, 3,
               8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        do_mem("lb_u", 64'h8000_0003, 2'd0, 1'b1, 1'b1, 64'h0, 64'h0000_0000_8000_0000, 3,
               8'h00, 64'h0, 64'h0000_0000_0000_0080, 1'b0);
        do_mem("sh", 64'h8000_0006, 2'd1, 1'b0, 1'b0, 64'hABCD, 64'hDEAD_BEEF_DEAD_BEEF, 1,
               8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 1'b0);
        do_mem("ld", 64'h4000_0000, 2'd3, 1'b0, 1'b1, 64'h0, 64'h1122_3344_5566_7788, 0,
               8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b1);
        do_mem("lw_s", 64'h8000_0004, 2'd2, 1'b0, 1'b1, 64'h0, 64'h8765_4321_0000_0000, 2,
               8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0);
        do_mem("sb", 64'h8000_0005, 2'd0, 1'b0, 1'b0, 64'h5A, 64'h0, 0,
               8'h20, 64'h0000_5A00_0000_0000, 64'h0, 1'b0);

        // Misaligned word load is dropped
        dataE           = '0;
        dataE.valid     = 1'b1;
        dataE.regwrite  = 1'b1;
        dataE.memtoreg  = 1'b1;
        dataE.memread   = 1'b1;
        dataE.pc        = 64'h8000_0200;
        dataE.aluout    = 64'h8000_0002;
        dataE.dst       = 5'd9;
        msize           = 2'd2;
        munsigned       = 1'b0;
        #1;
        chk("mis.stall", 64'(stallM), 64'd0);
        chk("mis.noreq0", 64'(dreq_valid), 64'd0);
        tick();
        dataE.valid = 1'b0;
        #1;
        chk("mis.pulse", 64'(misalign), 64'd1);
        chk("mis.valid", 64'(dataM.valid), 64'd1);
        chk("mis.regwrite", 64'(dataM.regwrite), 64'd0);
        chk("mis.noreq1", 64'(dreq_valid), 64'd0);
        tick();
        chk("mis.pulse_end", 64'(misalign), 64'd0);
        chk("mis.noreq2", 64'(dreq_valid), 64'd0);

        // Reset during an outstanding request
        dataE           = '0;
        dataE.valid     = 1'b1;
        dataE.memread   = 1'b1;
        dataE.regwrite  = 1'b1;
        dataE.aluout    = 64'h8000_0010;
        msize           = 2'd2;
        tick();
        chk("rreq.valid", 64'(dreq_valid), 64'd1);
        chk("rreq.stall", 64'(stallM), 64'd1);
        #2;
        resetn      = 1'b0;
        dataE.valid = 1'b0;
        #1;
        chk("rreq.async_drop", 64'(dreq_valid), 64'd0);
        chk("rreq.async_addr", dreq_addr, 64'd0);
        tick();
        resetn        = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("rreq.rel_stall", 64'(stallM), 64'd0);
        tick();
        dresp_data_ok = 1'b0;
        chk("rreq.late_ok_valid", 64'(dataM.valid), 64'd0);
        chk("rreq.late_ok_noreq", 64'(dreq_valid), 64'd0);
        chk("rreq.late_ok_stall", 64'(stallM), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

endmodule
